// File: rtl/core_test_ctrl.sv
// Test harness controller: holds a core in reset after power-up, lets it run,
// and latches the pass/fail/timeout verdict the core reports through a tohost write.
module core_test_ctrl #(
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter logic [31:0] TOHOST_ADDR     = 32'h0000_7F00,
  parameter int unsigned TIMEOUT_CYCLES  = 100000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        core_rstn,
  output logic [31:0] cycle_count,
  output logic        done,
  output logic        pass,
  output logic [30:0] fail_code,
  output logic        timeout,
  output logic [1:0]  state
);

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  localparam logic [15:0] HOLD_LAST    = 16'(RST_HOLD_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic        sync_meta;
  logic        rst_ok;
  logic [15:0] hold_cnt;
  logic        tohost_hit;
  logic [31:0] cycle_count_next;

  // Asynchronous assert, two-flop synchronous release.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync_meta <= 1'b0;
      rst_ok    <= 1'b0;
    end else begin
      sync_meta <= 1'b1;
      rst_ok    <= sync_meta;
    end
  end

  // A zero write is not a verdict; only non-zero data terminates the test.
  assign tohost_hit = mem_we && (mem_addr == TOHOST_ADDR) && (mem_wdata != 32'd0);

  assign cycle_count_next = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state       <= ST_HOLD;
      hold_cnt    <= 16'd0;
      core_rstn   <= 1'b0;
      cycle_count <= 32'd0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_code   <= 31'd0;
      timeout     <= 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (rst_ok) begin
            hold_cnt <= hold_cnt + 16'd1;
            if (hold_cnt == HOLD_LAST) begin
              state     <= ST_RUN;
              core_rstn <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          cycle_count <= cycle_count_next;
          // A verdict write takes priority over a watchdog expiry in the same cycle.
          if (tohost_hit) begin
            state     <= ST_DONE;
            core_rstn <= 1'b0;
            done      <= 1'b1;
            pass      <= (mem_wdata == 32'd1);
            fail_code <= mem_wdata[31:1];
          end else if (cycle_count == TIMEOUT_LAST) begin
            state     <= ST_TIMEOUT;
            core_rstn <= 1'b0;
            done      <= 1'b1;
            pass      <= 1'b0;
            timeout   <= 1'b1;
          end
        end
        default: begin
          // DONE and TIMEOUT are terminal until CPU_RESETN.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_test_ctrl.sv
// Directed bench for core_test_ctrl: a table of single tohost transactions plus
// hand-written reset, timeout and freeze sequences.
module tb_core_test_ctrl;

  localparam logic [31:0] TOHOST = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic        core_rstn;
  logic [31:0] cycle_count;
  logic        done;
  logic        pass;
  logic [30:0] fail_code;
  logic        timeout;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  core_test_ctrl #(
    .RST_HOLD_CYCLES(16),
    .TOHOST_ADDR(TOHOST),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .CLK100MHZ(clk),
    .CPU_RESETN(rst_n),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .core_rstn(core_rstn),
    .cycle_count(cycle_count),
    .done(done),
    .pass(pass),
    .fail_code(fail_code),
    .timeout(timeout),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idle;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  exp_state;
    logic        exp_pass;
    logic [30:0] exp_fail;
    logic [31:0] exp_cc;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " core_rstn"}, 64'(core_rstn), 64'd0);
    chk({tag, " cycle_count"}, 64'(cycle_count), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " pass"}, 64'(pass), 64'd0);
    chk({tag, " fail_code"}, 64'(fail_code), 64'd0);
    chk({tag, " timeout"}, 64'(timeout), 64'd0);
    chk({tag, " state"}, 64'(state), 64'd0);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    step(10);
    check_reset(tag);
  endtask

  // Releases reset and counts edges until core_rstn rises (bounded).
  task automatic release_and_check(input string tag);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    rst_n = 1'b1;
    while (n < 40 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (core_rstn) got = 1'b1;
    end
    chk({tag, " rise edge"}, 64'(n), 64'd18);
    chk({tag, " run state"}, 64'(state), 64'd1);
    chk({tag, " run cc"}, 64'(cycle_count), 64'd0);
  endtask

  initial begin
    //          idle we  addr        wdata          state  pass fail           cc
    vecs[0] = '{99,  1'b1, TOHOST,      32'h1,         2'd2, 1'b1, 31'd0,         32'd100};
    vecs[1] = '{10,  1'b1, TOHOST,      32'h7,         2'd2, 1'b0, 31'd3,         32'd11};
    vecs[2] = '{5,   1'b1, TOHOST + 4,  32'h1,         2'd1, 1'b0, 31'd0,         32'd6};
    vecs[3] = '{5,   1'b1, TOHOST,      32'h0,         2'd1, 1'b0, 31'd0,         32'd6};
    vecs[4] = '{5,   1'b0, TOHOST,      32'h1,         2'd1, 1'b0, 31'd0,         32'd6};
    vecs[5] = '{3,   1'b1, TOHOST,      32'hFFFF_FFFF, 2'd2, 1'b0, 31'h7FFF_FFFF, 32'd4};
    vecs[6] = '{0,   1'b1, TOHOST,      32'h2,         2'd2, 1'b0, 31'd1,         32'd1};
    vecs[7] = '{999, 1'b1, TOHOST,      32'h1,         2'd2, 1'b1, 31'd0,         32'd1000};

    #1;
    check_reset("por");

    for (int i = 0; i < 8; i++) begin
      string tag;
      logic  term;
      tag = $sformatf("vec%0d", i);
      do_reset(tag);
      release_and_check(tag);
      step(vecs[i].idle);
      mem_we = vecs[i].we;
      mem_addr = vecs[i].addr;
      mem_wdata = vecs[i].wdata;
      step(1);
      mem_we = 1'b0;
      mem_addr = 32'd0;
      mem_wdata = 32'd0;
      term = (vecs[i].exp_state != 2'd1);
      chk({tag, " state"}, 64'(state), 64'(vecs[i].exp_state));
      chk({tag, " done"}, 64'(done), 64'(term));
      chk({tag, " pass"}, 64'(pass), 64'(vecs[i].exp_pass));
      chk({tag, " fail_code"}, 64'(fail_code), 64'(vecs[i].exp_fail));
      chk({tag, " cc"}, 64'(cycle_count), 64'(vecs[i].exp_cc));
      chk({tag, " timeout"}, 64'(timeout), 64'd0);
      chk({tag, " core_rstn"}, 64'(core_rstn), 64'(!term));
      $display("vec%0d we=%0d addr=%h wdata=%h -> state=%0d done=%0d pass=%0d fail=%0h cc=%0d",
               i, vecs[i].we, vecs[i].addr, vecs[i].wdata, state, done, pass, fail_code, cycle_count);
      if (term) begin
        // Terminal state must ignore further bus traffic for 50 cycles.
        mem_we = 1'b1;
        mem_addr = TOHOST;
        for (int k = 0; k < 50; k++) begin
          mem_wdata = (k % 2 == 0) ? 32'h1 : 32'h9;
          step(1);
        end
        mem_we = 1'b0;
        chk({tag, " frozen state"}, 64'(state), 64'(vecs[i].exp_state));
        chk({tag, " frozen cc"}, 64'(cycle_count), 64'(vecs[i].exp_cc));
        chk({tag, " frozen pass"}, 64'(pass), 64'(vecs[i].exp_pass));
        chk({tag, " frozen fail"}, 64'(fail_code), 64'(vecs[i].exp_fail));
        chk({tag, " frozen core_rstn"}, 64'(core_rstn), 64'd0);
      end
    end

    // Watchdog expiry with no tohost write.
    do_reset("wdog");
    release_and_check("wdog");
    step(999);
    chk("wdog pre state", 64'(state), 64'd1);
    chk("wdog pre done", 64'(done), 64'd0);
    chk("wdog pre cc", 64'(cycle_count), 64'd999);
    step(1);
    chk("wdog state", 64'(state), 64'd3);
    chk("wdog done", 64'(done), 64'd1);
    chk("wdog timeout", 64'(timeout), 64'd1);
    chk("wdog pass", 64'(pass), 64'd0);
    chk("wdog cc", 64'(cycle_count), 64'd1000);
    chk("wdog core_rstn", 64'(core_rstn), 64'd0);
    $display("wdog -> state=%0d timeout=%0d cc=%0d", state, timeout, cycle_count);
    mem_we = 1'b1;
    mem_addr = TOHOST;
    mem_wdata = 32'h1;
    step(20);
    mem_we = 1'b0;
    chk("wdog frozen state", 64'(state), 64'd3);
    chk("wdog frozen cc", 64'(cycle_count), 64'd1000);
    chk("wdog frozen pass", 64'(pass), 64'd0);
    chk("wdog frozen timeout", 64'(timeout), 64'd1);

    // Reset asserted between edges mid-RUN.
    do_reset("midrun");
    release_and_check("midrun");
    step(500);
    chk("midrun cc", 64'(cycle_count), 64'd500);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset("midrun async");
    $display("midrun reset at cc=500 -> state=%0d core_rstn=%0d", state, core_rstn);
    step(10);
    release_and_check("midrun again");

    // Reset asserted while hold_cnt=5: core_rstn must never pulse.
    do_reset("hold");
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step(1);
      chk($sformatf("hold edge%0d core_rstn", k + 1), 64'(core_rstn), 64'd0);
    end
    rst_n = 1'b0;
    #1;
    check_reset("hold async");
    step(5);
    release_and_check("hold again");
    $display("hold reset at hold_cnt=5 -> restart state=%0d", state);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
